// File: rtl/gaussian_row_stage_if.sv
// gaussian_row_stage_if: pixel-in / filtered-out handshake bundle for gaussian_row_stage
interface gaussian_row_stage_if #(
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 16
);
    logic in_valid, in_ready, mode_byp, out_valid, out_ready, row_done;
    logic [DATA_W-1:0] in_data, out_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    modport master (
        output in_valid, in_data, mode_byp, out_ready,
        input in_ready, out_valid, out_data, row_done, fifo_level
    );
    modport slave (
        input in_valid, in_data, mode_byp, out_ready,
        output in_ready, out_valid, out_data, row_done, fifo_level
    );
endinterface

// File: rtl/gaussian_row_stage.sv
// gaussian_row_stage: streaming [1 4 6 4 1]/16 row filter with per-row bypass, edge discard and FWFT output FIFO
module gaussian_row_stage #(
    parameter int DATA_W = 8,
    parameter int LINE_W = 640,
    parameter int FIFO_DEPTH = 16
) (
    input logic clk,
    input logic rst,
    gaussian_row_stage_if.slave bus
);
    localparam int CW = $clog2(LINE_W);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = DATA_W + 4;
    logic [DATA_W-1:0] t [5];
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [CW-1:0] col;
    logic [AW-1:0] wp, rp;
    logic [LW-1:0] level;
    logic byp, byp_eff, wr_pend, acc, pop, row_done;
    logic [SW-1:0] sum;
    logic [DATA_W-1:0] wr_data;
    always_comb begin
        sum = SW'(t[0]) + SW'(t[4]) + ((SW'(t[1]) + SW'(t[3])) << 2) + (SW'(t[2]) << 2) + (SW'(t[2]) << 1);
        wr_data = byp ? t[0] : DATA_W'((sum + SW'(8)) >> 4);
        byp_eff = col == '0 ? bus.mode_byp : byp;
    end
    // level + wr_pend never exceeds FIFO_DEPTH, so the write side cannot overflow
    assign bus.in_ready = !rst && (level + LW'(wr_pend) < LW'(FIFO_DEPTH));
    assign acc = bus.in_valid && bus.in_ready;
    assign bus.out_valid = level != '0;
    assign pop = bus.out_valid && bus.out_ready;
    assign bus.out_data = bus.out_valid ? mem[rp] : '0;
    assign bus.fifo_level = level;
    assign bus.row_done = row_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            t <= '{default: '0};
            col <= '0;
            byp <= 1'b0;
            wr_pend <= 1'b0;
            row_done <= 1'b0;
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            wr_pend <= acc && (byp_eff || col >= CW'(4));
            row_done <= acc && col == CW'(LINE_W - 1);
            if (acc) begin
                t[0] <= bus.in_data;
                for (int i = 1; i < 5; i++) t[i] <= t[i-1];
                col <= col == CW'(LINE_W - 1) ? '0 : col + CW'(1);
                if (col == '0) byp <= bus.mode_byp;
            end
            if (wr_pend) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            level <= level + LW'(wr_pend) - LW'(pop);
        end
    end
    always_ff @(posedge clk) if (wr_pend) mem[wp] <= wr_data;
endmodule

// File: tb/tb_gaussian_row_stage.sv
// tb_gaussian_row_stage: table vectors, hand-written corner sequences and random rows against a row-level reference model
module tb_gaussian_row_stage;
    localparam int LW = 8;
    localparam int FD = 4;
    typedef struct packed {
        logic [39:0] w;
        logic byp;
        logic [7:0] exp;
    } vec_t;
    logic clk = 0, rst = 1;
    int total = 0, bad = 0;
    int exp_q[$];
    int got[$];
    int mrow[LW];
    int mcol = 0, rd_cnt = 0;
    bit mbyp = 0, rd_exp = 0;
    vec_t tbl[10];
    gaussian_row_stage_if #(.DATA_W(8), .FIFO_DEPTH(FD)) bus ();
    gaussian_row_stage #(.DATA_W(8), .LINE_W(LW), .FIFO_DEPTH(FD)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, want, $time);
        end
    endtask
    // row-level model: each accepted pixel is placed in its row; a result is due for every
    // bypass pixel or for every column whose 5-wide window lies inside the row
    always @(negedge clk) begin
        chk("row_done", int'(bus.row_done), int'(rd_exp));
        if (bus.row_done) rd_cnt++;
        if (rst) begin
            chk("rst_in_ready", int'(bus.in_ready), 0);
            mcol = 0;
            mbyp = 0;
            rd_exp = 0;
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(int'(bus.out_data));
                if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
                else chk("pop_data", int'(bus.out_data), exp_q.pop_front());
            end
            rd_exp = bus.in_valid && bus.in_ready && mcol == LW - 1;
            if (bus.in_valid && bus.in_ready) begin
                if (mcol == 0) mbyp = bus.mode_byp;
                mrow[mcol] = int'(bus.in_data);
                if (mbyp) exp_q.push_back(mrow[mcol]);
                else if (mcol >= 4)
                    exp_q.push_back((mrow[mcol-4] + 4*mrow[mcol-3] + 6*mrow[mcol-2] + 4*mrow[mcol-1] + mrow[mcol] + 8) / 16);
                mcol = (mcol + 1) % LW;
            end
        end
    end
    task automatic push(input logic [7:0] d, input logic m, input bit rnd);
        int n = 0;
        bit a = 0;
        if (rnd && $urandom_range(3) == 0) begin
            bus.in_valid = 0;
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
        end
        bus.in_valid = 1;
        bus.in_data = d;
        bus.mode_byp = m;
        while (!a && n < 200) begin
            if (rnd) bus.out_ready = $urandom_range(2) != 0;
            @(negedge clk);
            a = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!a) chk("push_timeout", 0, 1);
    endtask
    task automatic drain();
        int n = 0;
        bus.in_valid = 0;
        bus.out_ready = 1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size() + int'(bus.out_valid), 0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    initial begin
        logic [7:0] pix[8];
        int ex[4];
        int base, rds;
        logic [7:0] bv[8];
        tbl[0] = '{40'h00_01_01_01_00, 1'b0, 8'd1};
        tbl[1] = '{40'h00_00_01_00_00, 1'b0, 8'd0};
        tbl[2] = '{40'hFF_FF_FF_FF_FF, 1'b0, 8'd255};
        tbl[3] = '{40'h64_64_64_64_64, 1'b0, 8'd100};
        tbl[4] = '{40'h00_00_00_00_A0, 1'b0, 8'd10};
        tbl[5] = '{40'h00_00_A0_00_00, 1'b0, 8'd60};
        tbl[6] = '{40'h00_00_03_00_00, 1'b0, 8'd1};
        tbl[7] = '{40'h07_00_00_00_00, 1'b0, 8'd0};
        tbl[8] = '{40'h08_00_00_00_00, 1'b0, 8'd1};
        tbl[9] = '{40'h0A_14_1E_28_32, 1'b1, 8'd10};
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.mode_byp = 0;
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_level", int'(bus.fifo_level), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        rst = 0;
        #1;
        chk("ready_after_rst", int'(bus.in_ready), 1);
        // constant row: 4 results, one row_done
        base = got.size();
        rds = rd_cnt;
        for (int k = 0; k < LW; k++) push(8'd100, 1'b0, 1'b0);
        drain();
        chk("const_cnt", got.size() - base, 4);
        for (int k = 0; k < 4; k++) if (got.size() > base + k) chk("const_val", got[base+k], 100);
        chk("const_row_done", rd_cnt - rds, 1);
        // impulse at col 4
        pix = '{0, 0, 0, 0, 160, 0, 0, 0};
        ex = '{10, 40, 60, 40};
        base = got.size();
        for (int k = 0; k < LW; k++) push(pix[k], 1'b0, 1'b0);
        drain();
        chk("imp_cnt", got.size() - base, 4);
        for (int k = 0; k < 4; k++) if (got.size() > base + k) chk("imp_val", got[base+k], ex[k]);
        for (int i = 0; i < 10; i++) begin
            base = got.size();
            for (int k = 0; k < LW; k++)
                push(k < 5 ? tbl[i].w[39-8*k -: 8] : 8'($urandom), k == 0 ? tbl[i].byp : 1'b0, 1'b0);
            drain();
            chk("tbl_cnt", got.size() - base, tbl[i].byp ? LW : 4);
            if (got.size() > base) chk("tbl_val", got[base], int'(tbl[i].exp));
        end
        // bypass latched at col 0, mid-row toggle ignored, next row filters
        base = got.size();
        for (int k = 0; k < LW; k++) begin
            bv[k] = 8'($urandom);
            push(bv[k], k == 0, 1'b0);
        end
        drain();
        chk("byp_cnt", got.size() - base, LW);
        for (int k = 0; k < LW; k++) if (got.size() > base + k) chk("byp_val", got[base+k], int'(bv[k]));
        base = got.size();
        for (int k = 0; k < LW; k++) push(8'd50, 1'b0, 1'b0);
        drain();
        chk("post_byp_cnt", got.size() - base, 4);
        if (got.size() > base) chk("post_byp_val", got[base], 50);
        // stalled downstream: FIFO fills to 4, input blocks, then resumes losslessly
        base = got.size();
        bus.out_ready = 0;
        for (int k = 0; k < LW; k++) push(8'(10 * (k + 1)), 1'b0, 1'b0);
        bus.in_data = 8'd90;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_ready", int'(bus.in_ready), 0);
        chk("stall_level", int'(bus.fifo_level), FD);
        chk("stall_valid", int'(bus.out_valid), 1);
        chk("stall_head", int'(bus.out_data), 30);
        bus.out_ready = 1;
        for (int k = 0; k < LW; k++) push(8'(90 + 10 * k), 1'b0, 1'b0);
        drain();
        chk("stall_cnt", got.size() - base, 8);
        for (int k = 0; k < 8; k++) if (got.size() > base + k) chk("stall_val", got[base+k], 30 + 10 * (k < 4 ? k : k + 4));
        // reset mid-row with FIFO non-empty
        bus.out_ready = 0;
        for (int k = 0; k < 6; k++) push(8'($urandom), 1'b0, 1'b0);
        bus.in_valid = 0;
        chk("pre_rst_nonempty", int'(bus.fifo_level != 0), 1);
        rst = 1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_level", int'(bus.fifo_level), 0);
        rst = 0;
        bus.out_ready = 1;
        base = got.size();
        for (int k = 0; k < LW; k++) push(8'(200 - 20 * k), 1'b0, 1'b0);
        drain();
        chk("post_rst_cnt", got.size() - base, 4);
        // random rows with random bypass, gaps and downstream stalls
        for (int r = 0; r < 25; r++)
            for (int k = 0; k < LW; k++) push(8'($urandom), k == 0 ? ($urandom_range(2) == 0) : 1'($urandom), 1'b1);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
